gfp_mul_red_pipe: RTL

GFP_MUL_RED_PIPE -- requirements
Module: gfp_mul_red_pipe

---
 rtl/gfp_mul_red_pipe.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/gfp_mul_red_pipe.sv
// Four-stage GF(p) multiplier with Barrett reduction and an optional
// per-lane modular accumulator (MAC mode), all lanes sharing one handshake.
module gfp_mul_red_pipe #(
  parameter int P     = 251,
  parameter int W     = 8,
  parameter int LANES = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [LANES*W-1:0] i_a,
  input  logic [LANES*W-1:0] i_b,
  input  logic               i_mode,
  input  logic               i_clr,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [LANES*W-1:0] o_c
);

  localparam int XW = 2 * W;
  localparam int PW = 4 * W;
  localparam int RW = W + 2;
  localparam int SW = W + 1;
  localparam logic [PW-1:0] ONE_P = PW'(1);
  localparam logic [PW-1:0] P_EXT = PW'(P);
  localparam logic [PW-1:0] MU    = (ONE_P << XW) / P_EXT;
  localparam logic [RW-1:0] P_R   = RW'(P);
  localparam logic [SW-1:0] P_S   = SW'(P);

  // Handshake: a token moves in on i_valid && o_ready and out on
  // o_valid && i_ready; the whole pipe advances together or holds together.
  logic en;

  logic          s1_v_q, s1_v_d, s1_mode_q, s1_mode_d, s1_clr_q, s1_clr_d;
  logic [W-1:0]  s1_a_q [LANES];
  logic [W-1:0]  s1_a_d [LANES];
  logic [W-1:0]  s1_b_q [LANES];
  logic [W-1:0]  s1_b_d [LANES];
  logic          s2_v_q, s2_v_d, s2_mode_q, s2_mode_d, s2_clr_q, s2_clr_d;
  logic [XW-1:0] s2_x_q [LANES];
  logic [XW-1:0] s2_x_d [LANES];
  logic          s3_v_q, s3_v_d, s3_mode_q, s3_mode_d, s3_clr_q, s3_clr_d;
  logic [RW-1:0] s3_r0_q [LANES];
  logic [RW-1:0] s3_r0_d [LANES];
  logic          out_v_q, out_v_d;
  logic [W-1:0]  out_c_q [LANES];
  logic [W-1:0]  out_c_d [LANES];
  logic [W-1:0]  acc_q [LANES];
  logic [W-1:0]  acc_d [LANES];

  logic [PW-1:0] prod [LANES];
  logic [PW-1:0] quo  [LANES];
  logic [PW-1:0] qp   [LANES];
  logic [RW-1:0] r1   [LANES];
  logic [W-1:0]  r2   [LANES];
  logic [SW-1:0] sum0 [LANES];
  logic [W-1:0]  sum1 [LANES];

  // Barrett quotient may undershoot by up to 2, so r0 < 3P needs two fixups.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PW'(s2_x_q[k]) * MU;
      quo[k]  = prod[k] >> XW;
      qp[k]   = quo[k] * P_EXT;
      r1[k]   = (s3_r0_q[k] >= P_R) ? s3_r0_q[k] - P_R : s3_r0_q[k];
      r2[k]   = W'((r1[k] >= P_R) ? r1[k] - P_R : r1[k]);
      sum0[k] = (s3_clr_q ? '0 : {1'b0, acc_q[k]}) + {1'b0, r2[k]};
      sum1[k] = W'((sum0[k] >= P_S) ? sum0[k] - P_S : sum0[k]);
    end
  end

  always_comb begin
    en        = !out_v_q || i_ready;
    s1_v_d    = s1_v_q;
    s1_mode_d = s1_mode_q;
    s1_clr_d  = s1_clr_q;
    s2_v_d    = s2_v_q;
    s2_mode_d = s2_mode_q;
    s2_clr_d  = s2_clr_q;
    s3_v_d    = s3_v_q;
    s3_mode_d = s3_mode_q;
    s3_clr_d  = s3_clr_q;
    out_v_d   = out_v_q;
    if (en) begin
      s1_v_d    = i_valid;
      s1_mode_d = i_mode;
      s1_clr_d  = i_clr;
      s2_v_d    = s1_v_q;
      s2_mode_d = s1_mode_q;
      s2_clr_d  = s1_clr_q;
      s3_v_d    = s2_v_q;
      s3_mode_d = s2_mode_q;
      s3_clr_d  = s2_clr_q;
      out_v_d   = s3_v_q;
    end
    for (int k = 0; k < LANES; k++) begin
      s1_a_d[k]  = s1_a_q[k];
      s1_b_d[k]  = s1_b_q[k];
      s2_x_d[k]  = s2_x_q[k];
      s3_r0_d[k] = s3_r0_q[k];
      out_c_d[k] = out_c_q[k];
      acc_d[k]   = acc_q[k];
      if (en) begin
        s1_a_d[k]  = i_a[k*W +: W];
        s1_b_d[k]  = i_b[k*W +: W];
        s2_x_d[k]  = XW'(s1_a_q[k]) * XW'(s1_b_q[k]);
        s3_r0_d[k] = RW'(PW'(s2_x_q[k]) - qp[k]);
      end
      // Accumulator commits only on the edge the token enters the output register.
      if (en && s3_v_q) begin
        out_c_d[k] = s3_mode_q ? sum1[k] : r2[k];
        if (s3_mode_q) acc_d[k] = sum1[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v_q    <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_clr_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_mode_q <= 1'b0;
      s2_clr_q  <= 1'b0;
      s3_v_q    <= 1'b0;
      s3_mode_q <= 1'b0;
      s3_clr_q  <= 1'b0;
      out_v_q   <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_a_q[k]  <= '0;
        s1_b_q[k]  <= '0;
        s2_x_q[k]  <= '0;
        s3_r0_q[k] <= '0;
        out_c_q[k] <= '0;
        acc_q[k]   <= '0;
      end
    end else begin
      s1_v_q    <= s1_v_d;
      s1_mode_q <= s1_mode_d;
      s1_clr_q  <= s1_clr_d;
      s2_v_q    <= s2_v_d;
      s2_mode_q <= s2_mode_d;
      s2_clr_q  <= s2_clr_d;
      s3_v_q    <= s3_v_d;
      s3_mode_q <= s3_mode_d;
      s3_clr_q  <= s3_clr_d;
      out_v_q   <= out_v_d;
      for (int k = 0; k < LANES; k++) begin
        s1_a_q[k]  <= s1_a_d[k];
        s1_b_q[k]  <= s1_b_d[k];
        s2_x_q[k]  <= s2_x_d[k];
        s3_r0_q[k] <= s3_r0_d[k];
        out_c_q[k] <= out_c_d[k];
        acc_q[k]   <= acc_d[k];
      end
    end
  end

  always_comb begin
    o_c = '0;
    for (int k = 0; k < LANES; k++) o_c[k*W +: W] = out_c_q[k];
  end

  assign o_ready = en;
  assign o_valid = out_v_q;

endmodule
